ad56x3_spi_receiver: RTL and testbench

- Serial-side receiver for the AD5623/AD5643/AD5663 3-wire write protocol (SYNC/SCLK/DIN, 24-bit frames, data captured on SCLK falling edge).
- Oversamples all three lines in the clk domain and decodes each frame into command, address and data.
- Holds an input register and a DAC register per channel, A and B, and applies the datasheet command semantics to them.
- Used as a bit-accurate DAC stand-in for FPGA-in-loop tests of the DAC driver, and for board-to-board links that reuse the DAC serial format.

---
 rtl/ad56x3_spi_receiver.sv | 216 +++++++++++++++++++++
 tb/tb_ad56x3_spi_receiver.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ad56x3_spi_receiver.sv
// ad56x3_spi_receiver
//   Receiver for the AD5623/AD5643/AD5663 3-wire write protocol. SYNC, SCLK
//   and DIN are oversampled in the clk domain. Each 24-bit frame is decoded
//   into command, address and data. The command is then applied to a
//   per-channel input register and DAC register, following the datasheet
//   command semantics.
//
//   Ports:
//     clk, reset   system clock; asynchronous active-high reset
//     dacSync      frame enable, active low
//     dacSclk      serial clock; data is captured on its falling edge
//     dacDin       serial data, MSB first
//     frameValid   1-cycle strobe: a complete 24-bit frame was decoded
//     frameCmd     frame bits [21:19], held until the next frameValid
//     frameAddr    frame bits [18:16], held until the next frameValid
//     frameData    frame bits [15 -: DATA_WIDTH], held until the next frameValid
//     frameAbort   1-cycle strobe: SYNC rose before the 24th falling edge
//     outA, outB   DAC registers, offset binary or two's complement per SIGN_x
//     outUpdate    1-cycle strobe (with frameValid): a DAC register is written
//
//   The FSM state is kept in state_q (type state_t) so checkers can bind to it.

module ad56x3_spi_receiver #(
  parameter int    DATA_WIDTH  = 14,
  parameter string SIGN_A      = "UNSIGNED",
  parameter string SIGN_B      = "UNSIGNED",
  parameter int    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dacSync,
  input  logic                  dacSclk,
  input  logic                  dacDin,
  output logic                  frameValid,
  output logic [2:0]            frameCmd,
  output logic [2:0]            frameAddr,
  output logic [DATA_WIDTH-1:0] frameData,
  output logic                  frameAbort,
  output logic [DATA_WIDTH-1:0] outA,
  output logic [DATA_WIDTH-1:0] outB,
  output logic                  outUpdate
);

  localparam logic [DATA_WIDTH-1:0] MSB_MASK = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] FMT_A    = (SIGN_A == "SIGNED") ? MSB_MASK : '0;
  localparam logic [DATA_WIDTH-1:0] FMT_B    = (SIGN_B == "SIGNED") ? MSB_MASK : '0;

  // ---------------------------------------------------------------- input sync
  // All three lines use the same depth, so they stay mutually aligned.
  logic [SYNC_STAGES-1:0] sync_sr, sclk_sr, din_sr;
  logic                   sclk_d;
  logic                   sync_s, sclk_s, din_s, fe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_sr <= '1;
      sclk_sr <= '1;
      din_sr  <= '0;
      sclk_d  <= 1'b1;
    end else begin
      sync_sr <= {sync_sr[SYNC_STAGES-2:0], dacSync};
      sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], dacSclk};
      din_sr  <= {din_sr[SYNC_STAGES-2:0], dacDin};
      sclk_d  <= sclk_s;
    end
  end

  assign sync_s = sync_sr[SYNC_STAGES-1];
  assign sclk_s = sclk_sr[SYNC_STAGES-1];
  assign din_s  = din_sr[SYNC_STAGES-1];
  assign fe     = sclk_d & ~sclk_s;

  // ---------------------------------------------------------------- frame FSM
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [22:0] shift_q, shift_d;
  logic [23:0] frame_w;
  logic        valid_d, abort_d;
  logic        unused_frame_bits;

  // The 24th bit completes the frame straight from din_s, so only 23 bits are
  // stored. Bits [23:22] and the data LSBs below DATA_WIDTH are don't care.
  assign frame_w           = {shift_q, din_s};
  assign unused_frame_bits = ^frame_w;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    valid_d   = 1'b0;
    abort_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!sync_s) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = 5'd0;
        end
      end
      ST_SHIFT: begin
        // SYNC high wins over a coincident falling edge: the bit is dropped.
        if (sync_s) begin
          abort_d = 1'b1;
          state_d = ST_IDLE;
        end else if (fe) begin
          shift_d   = frame_w[22:0];
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd23) begin
            valid_d = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (sync_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 5'd0;
      shift_q    <= '0;
      frameValid <= 1'b0;
      frameAbort <= 1'b0;
      frameCmd   <= 3'd0;
      frameAddr  <= 3'd0;
      frameData  <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      frameValid <= valid_d;
      frameAbort <= abort_d;
      if (valid_d) begin
        frameCmd  <= frame_w[21:19];
        frameAddr <= frame_w[18:16];
        frameData <= frame_w[15 -: DATA_WIDTH];
      end
    end
  end

  // ---------------------------------------------------------- register bank
  logic [DATA_WIDTH-1:0] in_a_q, in_b_q, dac_a_q, dac_b_q;
  logic [DATA_WIDTH-1:0] in_a_d, in_b_d, dac_a_d, dac_b_d;
  logic                  sel_a, sel_b, wr_a, wr_b;

  assign sel_a = (frameAddr == 3'b000) || (frameAddr == 3'b111);
  assign sel_b = (frameAddr == 3'b001) || (frameAddr == 3'b111);

  always_comb begin
    in_a_d  = in_a_q;
    in_b_d  = in_b_q;
    dac_a_d = dac_a_q;
    dac_b_d = dac_b_q;
    wr_a    = 1'b0;
    wr_b    = 1'b0;
    if (frameValid) begin
      case (frameCmd)
        3'b000: begin
          if (sel_a) in_a_d = frameData;
          if (sel_b) in_b_d = frameData;
        end
        3'b001: begin
          if (sel_a) begin dac_a_d = in_a_q; wr_a = 1'b1; end
          if (sel_b) begin dac_b_d = in_b_q; wr_b = 1'b1; end
        end
        3'b010: begin
          // Both channels load from the post-write input registers.
          if (sel_a) in_a_d = frameData;
          if (sel_b) in_b_d = frameData;
          dac_a_d = in_a_d;
          dac_b_d = in_b_d;
          wr_a    = 1'b1;
          wr_b    = 1'b1;
        end
        3'b011: begin
          if (sel_a) begin in_a_d = frameData; dac_a_d = frameData; wr_a = 1'b1; end
          if (sel_b) begin in_b_d = frameData; dac_b_d = frameData; wr_b = 1'b1; end
        end
        3'b101: begin
          in_a_d  = '0;
          in_b_d  = '0;
          dac_a_d = '0;
          dac_b_d = '0;
          wr_a    = 1'b1;
          wr_b    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_a_q  <= '0;
      in_b_q  <= '0;
      dac_a_q <= '0;
      dac_b_q <= '0;
    end else begin
      in_a_q  <= in_a_d;
      in_b_q  <= in_b_d;
      dac_a_q <= dac_a_d;
      dac_b_q <= dac_b_d;
    end
  end

  assign outUpdate = wr_a | wr_b;
  // Flipping the MSB converts offset binary to two's complement.
  assign outA      = dac_a_q ^ FMT_A;
  assign outB      = dac_b_q ^ FMT_B;

endmodule

// File: tb/tb_ad56x3_spi_receiver.sv
// tb_ad56x3_spi_receiver
//   Directed bench for ad56x3_spi_receiver (DATA_WIDTH=14, SCLK = clk/8).
//   Two instances share the serial inputs: u_dut is UNSIGNED on both channels,
//   u_dut_s has SIGN_A="SIGNED". A table of frames is applied in order,
//   followed by hand-written sequences for over-long frames with a short SYNC
//   gap, and for reset asserted mid-frame.

module tb_ad56x3_spi_receiver;

  localparam int DW = 14;

  // ------------------------------------------------------ clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic dac_sync, dac_sclk, dac_din;

  logic          frame_valid, frame_abort, out_update;
  logic [2:0]    frame_cmd, frame_addr;
  logic [DW-1:0] frame_data, out_a, out_b;

  logic          s_frame_valid, s_frame_abort, s_out_update;
  logic [2:0]    s_frame_cmd, s_frame_addr;
  logic [DW-1:0] s_frame_data, s_out_a, s_out_b;

  ad56x3_spi_receiver #(.DATA_WIDTH(DW), .SIGN_A("UNSIGNED"), .SIGN_B("UNSIGNED"), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .reset(reset), .dacSync(dac_sync), .dacSclk(dac_sclk), .dacDin(dac_din),
    .frameValid(frame_valid), .frameCmd(frame_cmd), .frameAddr(frame_addr),
    .frameData(frame_data), .frameAbort(frame_abort), .outA(out_a), .outB(out_b),
    .outUpdate(out_update)
  );

  ad56x3_spi_receiver #(.DATA_WIDTH(DW), .SIGN_A("SIGNED"), .SIGN_B("UNSIGNED"), .SYNC_STAGES(2)) u_dut_s (
    .clk(clk), .reset(reset), .dacSync(dac_sync), .dacSclk(dac_sclk), .dacDin(dac_din),
    .frameValid(s_frame_valid), .frameCmd(s_frame_cmd), .frameAddr(s_frame_addr),
    .frameData(s_frame_data), .frameAbort(s_frame_abort), .outA(s_out_a), .outB(s_out_b),
    .outUpdate(s_out_update)
  );

  // ------------------------------------------------------ strobe counters
  int valid_cnt = 0, abort_cnt = 0, upd_cnt = 0;

  always @(negedge clk) begin
    if (frame_valid) valid_cnt++;
    if (frame_abort) abort_cnt++;
    if (out_update)  upd_cnt++;
  end

  // ------------------------------------------------------ scoreboard
  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------ driver tasks
  task automatic sclk_edge(input logic bit_v);
    dac_din = bit_v;
    repeat (4) @(posedge clk);
    dac_sclk = 1'b0;
    repeat (4) @(posedge clk);
    dac_sclk = 1'b1;
  endtask

  // Edges past the 24th drive DIN high so that any capture of them is visible.
  task automatic send_frame(input logic [23:0] frame, input int n_edges, input int gap);
    dac_sync = 1'b0;
    repeat (4) @(posedge clk);
    for (int i = 0; i < n_edges; i++)
      sclk_edge((i < 24) ? frame[23-i] : 1'b1);
    repeat (4) @(posedge clk);
    dac_sync = 1'b1;
    repeat (gap) @(posedge clk);
  endtask

  // ------------------------------------------------------ vector table
  typedef struct {
    logic [23:0]   frame;
    int            edges;
    int            exp_valid;
    int            exp_abort;
    int            exp_upd;
    logic [2:0]    cmd;
    logic [2:0]    addr;
    logic [DW-1:0] data;
    logic [DW-1:0] out_a;
    logic [DW-1:0] out_b;
    logic [DW-1:0] out_a_s;
  } vec_t;

  vec_t vecs[8];

  int v0, a0, u0;

  task automatic check_outputs(input string tag, input logic [2:0] cmd, input logic [2:0] addr,
                               input logic [DW-1:0] data, input logic [DW-1:0] oa,
                               input logic [DW-1:0] ob, input logic [DW-1:0] oas);
    check({tag, "_cmd"},   frame_cmd,  cmd);
    check({tag, "_addr"},  frame_addr, addr);
    check({tag, "_data"},  frame_data, data);
    check({tag, "_outA"},  out_a,      oa);
    check({tag, "_outB"},  out_b,      ob);
    check({tag, "_outAs"}, s_out_a,    oas);
  endtask

  initial begin
    vecs[0] = '{24'h0048D0, 24, 1, 0, 0, 3'd0, 3'd0, 14'h1234, 14'h0000, 14'h0000, 14'h2000};
    vecs[1] = '{24'h112AF0, 24, 1, 0, 1, 3'd2, 3'd1, 14'h0ABC, 14'h1234, 14'h0ABC, 14'h3234};
    vecs[2] = '{24'h1FFFFC, 24, 1, 0, 1, 3'd3, 3'd7, 14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h1FFF};
    vecs[3] = '{24'h280000, 24, 1, 0, 1, 3'd5, 3'd0, 14'h0000, 14'h0000, 14'h0000, 14'h2000};
    vecs[4] = '{24'h1848D0, 10, 0, 1, 0, 3'd5, 3'd0, 14'h0000, 14'h0000, 14'h0000, 14'h2000};
    vecs[5] = '{24'h1848D0, 24, 1, 0, 1, 3'd3, 3'd0, 14'h1234, 14'h1234, 14'h0000, 14'h3234};
    vecs[6] = '{24'h188000, 24, 1, 0, 1, 3'd3, 3'd0, 14'h2000, 14'h2000, 14'h0000, 14'h0000};
    vecs[7] = '{24'h180000, 24, 1, 0, 1, 3'd3, 3'd0, 14'h0000, 14'h0000, 14'h0000, 14'h2000};

    dac_sync = 1'b1;
    dac_sclk = 1'b1;
    dac_din  = 1'b0;
    reset    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid",  frame_valid, 0);
    check("rst_abort",  frame_abort, 0);
    check("rst_update", out_update,  0);
    check_outputs("rst", 3'd0, 3'd0, '0, '0, '0, 14'h2000);
    reset = 1'b0;
    repeat (5) @(posedge clk);

    // Table-driven frames
    for (int i = 0; i < 8; i++) begin
      v0 = valid_cnt; a0 = abort_cnt; u0 = upd_cnt;
      send_frame(vecs[i].frame, vecs[i].edges, 10);
      @(negedge clk);
      check($sformatf("v%0d_valid_n",  i), valid_cnt - v0, vecs[i].exp_valid);
      check($sformatf("v%0d_abort_n",  i), abort_cnt - a0, vecs[i].exp_abort);
      check($sformatf("v%0d_update_n", i), upd_cnt - u0,   vecs[i].exp_upd);
      check_outputs($sformatf("v%0d", i), vecs[i].cmd, vecs[i].addr, vecs[i].data,
                    vecs[i].out_a, vecs[i].out_b, vecs[i].out_a_s);
    end

    // 26 falling edges, then only 3 clk of SYNC high before the next frame
    v0 = valid_cnt; a0 = abort_cnt; u0 = upd_cnt;
    send_frame(24'h1F0004, 26, 3);
    check("long_valid_n", valid_cnt - v0, 1);
    check("long_outA",    out_a,          14'h0001);
    send_frame(24'h198008, 24, 10);
    @(negedge clk);
    check("b2b_valid_n",  valid_cnt - v0, 2);
    check("b2b_abort_n",  abort_cnt - a0, 0);
    check("b2b_update_n", upd_cnt - u0,   2);
    check_outputs("b2b", 3'd3, 3'd1, 14'h2002, 14'h0001, 14'h2002, 14'h2001);

    // Reset asserted partway through a frame
    dac_sync = 1'b0;
    repeat (4) @(posedge clk);
    for (int i = 0; i < 12; i++) sclk_edge(1'b1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_rst_valid", frame_valid, 0);
    check("mid_rst_abort", frame_abort, 0);
    check_outputs("mid_rst", 3'd0, 3'd0, '0, '0, '0, 14'h2000);
    dac_sync = 1'b1;
    dac_sclk = 1'b1;
    repeat (3) @(posedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    v0 = valid_cnt; a0 = abort_cnt; u0 = upd_cnt;
    send_frame(24'h1848D0, 24, 10);
    @(negedge clk);
    check("post_rst_valid_n",  valid_cnt - v0, 1);
    check("post_rst_abort_n",  abort_cnt - a0, 0);
    check("post_rst_update_n", upd_cnt - u0,   1);
    check_outputs("post_rst", 3'd3, 3'd0, 14'h1234, 14'h1234, 14'h0000, 14'h3234);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
